// File: rtl/dot_accel.sv
// Avalon-MM dot-product engine: fetches weight/activation vectors over the master port
// and accumulates a wrapping Q(32-FRAC_BITS).FRAC_BITS dot product readable at offset 0.
module dot_accel #(
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic [31:0]       slave_readdata,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [31:0]       master_writedata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_W,
        WT_W,
        RD_A,
        WT_A,
        MAC,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] wbase, abase, len, result;
    logic [31:0] wbase_q, abase_q, len_q;
    logic [31:0] idx, acc, w_q, a_q;
    logic [31:0] idx_inc, mac_term;
    logic        start, more;

    assign start    = slave_write && (slave_address == 4'd0);
    assign idx_inc  = idx + 32'd1;
    assign more     = idx_inc < len_q;
    // Sign-extend both operands to 64 bits so the full product is kept before the
    // arithmetic shift (floor rounding) and the wrap back to 32 bits.
    assign mac_term = 32'((64'($signed(w_q)) * 64'($signed(a_q))) >>> FRAC_BITS);

    assign master_write      = 1'b0;
    assign master_writedata  = '0;
    assign slave_waitrequest = slave_read && (slave_address == 4'd0) && (state != IDLE);

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            4'd0:    slave_readdata = result;
            4'd2:    slave_readdata = wbase;
            4'd3:    slave_readdata = abase;
            4'd5:    slave_readdata = len;
            default: slave_readdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wbase          <= '0;
            abase          <= '0;
            len            <= '0;
            result         <= '0;
            wbase_q        <= '0;
            abase_q        <= '0;
            len_q          <= '0;
            idx            <= '0;
            acc            <= '0;
            w_q            <= '0;
            a_q            <= '0;
            master_read    <= 1'b0;
            master_address <= '0;
        end else begin
            if (slave_write) begin
                case (slave_address)
                    4'd2:    wbase <= slave_writedata;
                    4'd3:    abase <= slave_writedata;
                    4'd5:    len   <= slave_writedata;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        wbase_q <= wbase;
                        abase_q <= abase;
                        len_q   <= len;
                        acc     <= '0;
                        idx     <= '0;
                        if (len == 32'd0) begin
                            state <= DONE;
                        end else begin
                            master_read    <= 1'b1;
                            master_address <= ADDR_W'(wbase);
                            state          <= RD_W;
                        end
                    end
                end
                RD_W: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        state       <= WT_W;
                    end
                end
                WT_W: begin
                    if (master_readdatavalid) begin
                        w_q            <= master_readdata;
                        master_read    <= 1'b1;
                        master_address <= ADDR_W'(abase_q + (idx << 2));
                        state          <= RD_A;
                    end
                end
                RD_A: begin
                    if (!master_waitrequest) begin
                        master_read <= 1'b0;
                        state       <= WT_A;
                    end
                end
                WT_A: begin
                    if (master_readdatavalid) begin
                        a_q   <= master_readdata;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + mac_term;
                    idx <= idx_inc;
                    if (more) begin
                        master_read    <= 1'b1;
                        master_address <= ADDR_W'(wbase_q + (idx_inc << 2));
                        state          <= RD_W;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    result <= acc;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
